// File: rtl/fp_pkg.sv
// Shared FP datapath types.
// Opcodes, unit error codes and issue-stage states.
package fp_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } opcode_t;

    typedef logic [2:0] o_err_t;

    localparam o_err_t ERR_NONE = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        AS_WAIT,
        MUL_STRB,
        MUL_WAIT,
        DIV_WAIT,
        DONE
    } issue_state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fp_issue_wdog.sv
// Issue-stage watchdog counter.
// Saturating cycle count with latency and timeout compares.
module fp_issue_wdog #(
    parameter int DIV_LAT = 30,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic lat_ok,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // count wait cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lat_ok  = (cnt >= LAT_C);
    assign expired = (cnt == TMO_C);

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue stage: routes one op to add/sub, mul or div.
// Captures the result and hands it downstream.
module fp_issue_ctrl
    import fp_pkg::*;
#(
    parameter int DIV_LAT = 30,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  opcode_t     req_opc,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output o_err_t      res_err,
    output logic        res_timeout,
    output logic        as_op,
    output logic [31:0] as_a,
    output logic [31:0] as_b,
    input  logic [31:0] as_out,
    input  o_err_t      as_err,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_strb_a,
    output logic        mul_strb_b,
    input  logic        mul_ack_a,
    input  logic        mul_ack_b,
    input  logic [31:0] mul_out,
    input  logic        mul_out_stb,
    output logic        mul_out_ack,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_ena,
    input  logic        div_busy,
    input  logic [31:0] div_s,
    input  o_err_t      div_err
);

    issue_state_t state, state_d;
    opcode_t      op_q, op_d;
    logic [31:0]  a_q, a_d;
    logic [31:0]  b_q, b_d;

    logic         req_ready_d;
    logic         res_valid_d;
    logic [31:0]  data_d;
    o_err_t       err_d;
    logic         to_d;
    logic         strb_a_d;
    logic         strb_b_d;
    logic         out_ack_d;
    logic         div_ena_d;

    logic         cnt_clr;
    logic         cnt_en;
    logic         lat_ok;
    logic         expired;

    fp_issue_wdog #(
        .DIV_LAT (DIV_LAT),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .lat_ok  (lat_ok),
        .expired (expired)
    );

    assign as_op = (op_q == OP_SUB);
    assign as_a  = a_q;
    assign as_b  = b_q;
    assign mul_a = a_q;
    assign mul_b = b_q;
    assign div_a = a_q;
    assign div_b = b_q;

    // next state and next value of every registered output
    always_comb begin
        state_d     = state;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        req_ready_d = req_ready;
        res_valid_d = res_valid;
        data_d      = res_data;
        err_d       = res_err;
        to_d        = res_timeout;
        strb_a_d    = mul_strb_a;
        strb_b_d    = mul_strb_b;
        out_ack_d   = 1'b0;
        div_ena_d   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    op_d        = req_opc;
                    a_d         = req_a;
                    b_d         = req_b;
                    cnt_clr     = 1'b1;
                    to_d        = 1'b0;
                    err_d       = ERR_NONE;
                    unique case (1'b1)
                        (req_opc == OP_ADD) ||
                        (req_opc == OP_SUB): begin
                            state_d = AS_WAIT;
                        end
                        (req_opc == OP_MUL): begin
                            state_d  = MUL_STRB;
                            strb_a_d = 1'b1;
                            strb_b_d = 1'b1;
                        end
                        (req_opc == OP_DIV): begin
                            state_d   = DIV_WAIT;
                            div_ena_d = 1'b1;
                        end
                        default: begin
                            state_d     = DONE;
                            data_d      = FP_QNAN;
                            res_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            AS_WAIT: begin
                data_d      = as_out;
                err_d       = as_err;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            MUL_STRB: begin
                cnt_en   = 1'b1;
                strb_a_d = mul_strb_a && !mul_ack_a;
                strb_b_d = mul_strb_b && !mul_ack_b;
                if (expired) begin
                    strb_a_d    = 1'b0;
                    strb_b_d    = 1'b0;
                    data_d      = FP_QNAN;
                    err_d       = ERR_NONE;
                    to_d        = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (!strb_a_d && !strb_b_d) begin
                    state_d = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                cnt_en = 1'b1;
                if (mul_out_stb) begin
                    data_d      = mul_out;
                    err_d       = ERR_NONE;
                    out_ack_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (expired) begin
                    data_d      = FP_QNAN;
                    err_d       = ERR_NONE;
                    to_d        = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DIV_WAIT: begin
                cnt_en = 1'b1;
                if (lat_ok && !div_busy) begin
                    data_d      = div_s;
                    err_d       = div_err;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (expired) begin
                    data_d      = FP_QNAN;
                    err_d       = ERR_NONE;
                    to_d        = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, operand and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            req_ready   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= ERR_NONE;
            res_timeout <= 1'b0;
            mul_strb_a  <= 1'b0;
            mul_strb_b  <= 1'b0;
            mul_out_ack <= 1'b0;
            div_ena     <= 1'b0;
        end else begin
            state       <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            req_ready   <= req_ready_d;
            res_valid   <= res_valid_d;
            res_data    <= data_d;
            res_err     <= err_d;
            res_timeout <= to_d;
            mul_strb_a  <= strb_a_d;
            mul_strb_b  <= strb_b_d;
            mul_out_ack <= out_ack_d;
            div_ena     <= div_ena_d;
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: unit responders plus a
// transaction-level model of result, error, flag and latency.
module tb_fp_issue_ctrl;
    import fp_pkg::*;

    localparam int DLAT = 30;
    localparam int TMO  = 64;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    opcode_t     req_opc;
    logic [31:0] req_a, req_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    o_err_t      res_err;
    logic        res_timeout;
    logic        as_op;
    logic [31:0] as_a, as_b, as_out;
    o_err_t      as_err;
    logic [31:0] mul_a, mul_b, mul_out;
    logic        mul_strb_a, mul_strb_b;
    logic        mul_ack_a, mul_ack_b;
    logic        mul_out_stb, mul_out_ack;
    logic [31:0] div_a, div_b, div_s;
    logic        div_ena, div_busy;
    o_err_t      div_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_issue_ctrl #(.DIV_LAT(DLAT), .TIMEOUT(TMO), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opc(req_opc), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .res_timeout(res_timeout),
        .as_op(as_op), .as_a(as_a), .as_b(as_b),
        .as_out(as_out), .as_err(as_err),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_strb_a(mul_strb_a), .mul_strb_b(mul_strb_b),
        .mul_ack_a(mul_ack_a), .mul_ack_b(mul_ack_b),
        .mul_out(mul_out), .mul_out_stb(mul_out_stb),
        .mul_out_ack(mul_out_ack),
        .div_a(div_a), .div_b(div_b), .div_ena(div_ena),
        .div_busy(div_busy), .div_s(div_s), .div_err(div_err)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{req_ready, res_valid, res_data, res_err, res_timeout,
                 as_op, as_a, as_b, mul_a, mul_b, mul_strb_a,
                 mul_strb_b, mul_out_ack, div_a, div_b, div_ena};
    endfunction

    // Outcome of one op from the unit timing the responders will follow.
    // Times are counted in edges after the accepting edge.
    function automatic void model(input opcode_t opc,
                                  input int ta, tb, ts, tbusy,
                                  input logic [31:0] rv,
                                  input logic [2:0] ev,
                                  output int lat,
                                  output logic [31:0] d,
                                  output logic [2:0] e,
                                  output logic to);
        int p;
        to = 1'b0;
        e  = 3'd0;
        d  = FP_QNAN;
        lat = 0;
        if (opc == OP_ADD || opc == OP_SUB) begin
            lat = 1;
            d = rv;
            e = ev;
        end else if (opc == OP_MUL || opc == OP_DIV) begin
            if (opc == OP_MUL) begin
                p = (ta > tb) ? ta + 1 : tb + 1;
                if (ts > p) p = ts;
            end else begin
                p = (tbusy > DLAT) ? tbusy : DLAT;
            end
            if (p <= TMO) begin
                lat = p + 1;
                d = rv;
                e = (opc == OP_DIV) ? ev : 3'd0;
            end else begin
                lat = TMO + 1;
                to = 1'b1;
            end
        end
    endfunction

    task automatic run_op(input opcode_t opc, input logic [31:0] a, b,
                          input int ta, tb, ts, tbusy,
                          input logic [31:0] rv, input logic [2:0] ev,
                          input int stall, gap, output time t_acc);
        int lat;
        logic [31:0] ed;
        logic [2:0] ee;
        logic eto, got;
        logic [31:0] held;
        model(opc, ta, tb, ts, tbusy, rv, ev, lat, ed, ee, eto);
        as_out = rv; as_err = ev; mul_out = rv;
        div_s = rv; div_err = ev;
        repeat (gap) begin
            @(posedge clk); @(negedge clk);
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_opc = opc; req_a = a; req_b = b;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
        got = 1'b0;
        for (int p = 0; p <= lat + 3; p++) begin
            mul_ack_a = (p >= ta) && mul_strb_a;
            mul_ack_b = (p >= tb) && mul_strb_b;
            mul_out_stb = (p >= ts) && !mul_out_ack && !res_valid;
            div_busy = (p < tbusy);
            if (p == 0) begin
                check("as_a", as_a, a);
                check("as_b", as_b, b);
                check("as_op", 32'(as_op), 32'(opc == OP_SUB));
                check("mul_a", mul_a, a);
                check("mul_b", mul_b, b);
                check("div_a", div_a, a);
                check("div_b", div_b, b);
                check("req_ready_busy", 32'(req_ready), 32'd0);
            end
            check("strb_a", 32'(mul_strb_a),
                  32'(opc == OP_MUL && p <= ta && p <= TMO));
            check("strb_b", 32'(mul_strb_b),
                  32'(opc == OP_MUL && p <= tb && p <= TMO));
            check("div_ena", 32'(div_ena), 32'(opc == OP_DIV && p == 0));
            check("out_ack", 32'(mul_out_ack),
                  32'(opc == OP_MUL && !eto && p == lat));
            if (res_valid) begin
                got = 1'b1;
                check("latency", 32'(p), 32'(lat));
                check("res_data", res_data, ed);
                check("res_err", 32'(res_err), 32'(ee));
                check("res_timeout", 32'(res_timeout), 32'(eto));
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        if (!got) check("res_valid_bound", 32'(res_valid), 32'd1);
        mul_ack_a = 1'b0; mul_ack_b = 1'b0;
        mul_out_stb = 1'b0; div_busy = 1'b0;
        held = res_data;
        for (int s = 0; s < stall; s++) begin
            res_ready = 1'b0;
            @(posedge clk); @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", res_data, held);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_ack", 32'(mul_out_ack), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready = 1'b0;
        check("after_valid", 32'(res_valid), 32'd0);
        check("after_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end

    initial begin
        int lat, r, ta, tb, ts, tbusy;
        logic [31:0] d;
        logic [2:0] e;
        logic to, seen;
        time t0, t1;
        opcode_t o;

        rst = 1'b1; req_valid = 1'b0; req_opc = OP_ADD;
        req_a = '0; req_b = '0; res_ready = 1'b0;
        as_out = '0; as_err = '0; mul_ack_a = 1'b0; mul_ack_b = 1'b0;
        mul_out = '0; mul_out_stb = 1'b0; div_busy = 1'b0;
        div_s = '0; div_err = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(any_out()), 32'd0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        model(OP_ADD, 0, 0, 0, 0, 32'h40400000, 3'd0, lat, d, e, to);
        check("model_add_lat", 32'(lat), 32'd1);
        model(OP_MUL, 1, 3, 6, 0, 32'h40C00000, 3'd0, lat, d, e, to);
        check("model_mul_lat", 32'(lat), 32'd7);
        model(OP_DIV, 0, 0, 0, 5, 32'h40400000, 3'd0, lat, d, e, to);
        check("model_div_lat", 32'(lat), 32'd31);
        model(OP_MUL, 0, 2, NEVER, 0, 32'h1, 3'd0, lat, d, e, to);
        check("model_tmo_lat", 32'(lat), 32'd65);
        check("model_tmo_data", d, 32'h7FC00000);
        model(OP_DIV, 0, 0, 0, 64, 32'h1, 3'd0, lat, d, e, to);
        check("model_edge_to", 32'(to), 32'd0);

        run_op(OP_ADD, 32'h3F800000, 32'h40000000, 0, 0, 0, 0,
               32'h40400000, 3'd0, 0, 0, t0);
        run_op(OP_SUB, 32'h40400000, 32'h3F800000, 0, 0, 0, 0,
               32'h40000000, 3'd0, 0, 0, t1);
        check("throughput", 32'(t1 - t0), 32'd30);
        run_op(OP_MUL, 32'h40000000, 32'h40400000, 1, 3, 6, 0,
               32'h40C00000, 3'd0, 0, 1, t0);
        run_op(OP_DIV, 32'h40C00000, 32'h40000000, 0, 0, 0, 5,
               32'h40400000, 3'd0, 0, 0, t0);
        run_op(OP_MUL, 32'h1, 32'h2, 0, 2, NEVER, 0,
               32'h12345678, 3'd0, 0, 0, t0);
        run_op(OP_MUL, 32'h3, 32'h4, NEVER, NEVER, 0, 0,
               32'h12345678, 3'd0, 1, 0, t0);
        run_op(OP_DIV, 32'h5, 32'h6, 0, 0, 0, 64,
               32'h3F000000, 3'd3, 0, 0, t0);
        run_op(OP_DIV, 32'h7, 32'h8, 0, 0, 0, 65,
               32'h3F000000, 3'd3, 0, 0, t0);
        run_op(OP_ADD, 32'hAAAA5555, 32'h0F0F0F0F, 0, 0, 0, 0,
               32'hDEADBEEF, 3'd2, 10, 0, t0);
        run_op(opcode_t'(3'd5), 32'h9, 32'hA, 0, 0, 0, 0,
               32'h11111111, 3'd4, 0, 0, t0);

        req_valid = 1'b1; req_opc = OP_DIV;
        req_a = 32'h40C00000; req_b = 32'h40000000;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; div_busy = 1'b1;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midop_reset", 32'(any_out()), 32'd0);
        rst = 1'b0; div_busy = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("aborted_no_result", 32'(seen), 32'd0);
        check("idle_after_abort", 32'(req_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 15);
            o = (r < 12) ? opcode_t'(3'(r % 4))
                         : opcode_t'(3'(4 + r % 4));
            ta = $urandom_range(0, 6);
            tb = $urandom_range(0, 6);
            ts = $urandom_range(0, 12);
            tbusy = $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0) begin
                ts = 70; tbusy = 70;
            end
            run_op(o, $urandom, $urandom, ta, tb, ts, tbusy,
                   $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, 2), t0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
